// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler
//   Shares one multdiv unit between two requesters using round-robin
//   arbitration. The accepted operation's operands are latched and held on
//   the multdiv inputs; a one-cycle ctrl_MULT/ctrl_DIV pulse starts the unit.
//   The scheduler then waits for data_resultRDY and returns the result to the
//   requester that owns the operation. A watchdog forces completion with an
//   exception if the unit never answers.
//
//   Optional feature macro: MULTDIV_SCHED_DIV0_FAST_EN
//     When defined, a divide with B==0 completes directly from accept
//     (result=0, rem=0, exception=1) and the multdiv unit is never pulsed.
//
// Ports
//   clock, reset_n          clock (rising edge), async active-low reset
//   req_valid[1:0]          requester i has an operation pending
//   req_div[1:0]            per requester: 1=divide, 0=multiply
//   req_a0/req_b0           operands of requester 0
//   req_a1/req_b1           operands of requester 1
//   req_ready[1:0]          combinational grant (IDLE only)
//   rsp_valid[1:0]          one-cycle completion pulse per requester
//   rsp_result/rsp_rem      product or quotient / remainder (0 for multiply)
//   rsp_exception           overflow, divide-by-zero or timeout
//   busy                    high whenever not IDLE
//   md_operandA/B           held operands to the multdiv unit
//   md_ctrl_MULT/DIV        single-cycle start pulses
//   md_result/md_rem        multdiv result and remainder
//   md_exception            multdiv exception flag
//   md_resultRDY            multdiv result ready
module multdiv_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_div,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_rem,
  output logic        rsp_exception,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic [31:0] md_rem,
  input  logic        md_exception,
  input  logic        md_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             rr_last;
  logic             owner;
  logic             op_div;
  logic [CNT_W-1:0] wdog;

  logic [1:0]  grant;
  logic        accept;
  logic        acc_owner;
  logic        acc_div;
  logic [31:0] acc_a;
  logic [31:0] acc_b;

  // Sole valid requester wins; on a tie the one that did not win last time.
  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign acc_owner = grant[1];
  assign busy      = (state != S_IDLE);

  always_comb begin
    acc_div = acc_owner ? req_div[1] : req_div[0];
    acc_a   = acc_owner ? req_a1     : req_a0;
    acc_b   = acc_owner ? req_b1     : req_b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rr_last       <= 1'b1;
      owner         <= 1'b0;
      op_div        <= 1'b0;
      wdog          <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_rem       <= '0;
      rsp_exception <= 1'b0;
      md_operandA   <= '0;
      md_operandB   <= '0;
      md_ctrl_MULT  <= 1'b0;
      md_ctrl_DIV   <= 1'b0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      rsp_valid    <= '0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            md_operandA <= acc_a;
            md_operandB <= acc_b;
            op_div      <= acc_div;
            owner       <= acc_owner;
            rr_last     <= acc_owner;
`ifdef MULTDIV_SCHED_DIV0_FAST_EN
            if (acc_div && (acc_b == '0)) begin
              rsp_result    <= '0;
              rsp_rem       <= '0;
              rsp_exception <= 1'b1;
              rsp_valid     <= acc_owner ? 2'b10 : 2'b01;
              state         <= S_RESP;
            end else begin
              md_ctrl_MULT <= ~acc_div;
              md_ctrl_DIV  <= acc_div;
              state        <= S_ISSUE;
            end
`else
            md_ctrl_MULT <= ~acc_div;
            md_ctrl_DIV  <= acc_div;
            state        <= S_ISSUE;
`endif
          end
        end
        // Start pulse is visible during this state; RDY is not sampled here.
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (md_resultRDY) begin
            rsp_result    <= md_result;
            rsp_rem       <= op_div ? md_rem : '0;
            rsp_exception <= md_exception;
            rsp_valid     <= owner ? 2'b10 : 2'b01;
            state         <= S_RESP;
          end else if (wdog == WDOG_LAST) begin
            rsp_result    <= '0;
            rsp_rem       <= '0;
            rsp_exception <= 1'b1;
            rsp_valid     <= owner ? 2'b10 : 2'b01;
            state         <= S_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
